// File: rtl/decode_stage.sv
// RV32I-subset ID stage: decodes ADD/SUB, ADDI, BEQ/BNE and LUI into a registered
// bundle behind a 1-entry skid buffer. Optional macro DECODE_ILLEGAL_EN adds illegal flagging + halt.
module decode_stage #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  input  logic            flush,
  output logic            id_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_imm,
  output logic            id_src_imm,
  output logic            id_alu_sub,
  output logic            id_lui,
  output logic            id_branch,
  output logic            id_br_ne,
  output logic            id_we,
  output logic            id_illegal
);

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            src_imm;
    logic            alu_sub;
    logic            lui;
    logic            branch;
    logic            br_ne;
    logic            we;
`ifdef DECODE_ILLEGAL_EN
    logic            illegal;
`endif
  } bundle_t;

  // Unsupported encodings decode to an all-zero bundle, which EX treats as a NOP.
  function automatic bundle_t decode(input logic [31:0] inst);
    bundle_t    b;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       ok;
    b      = '0;
    opcode = inst[6:2];
    funct3 = inst[14:12];
    funct7 = inst[31:25];
    ok     = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP: if (funct3 == 3'b000 && (funct7 & 7'b1011111) == 7'b0) begin
          ok        = 1'b1;
          b.rs1     = inst[19:15];
          b.rs2     = inst[24:20];
          b.rd      = inst[11:7];
          b.alu_sub = funct7[5];
          b.we      = (inst[11:7] != 5'd0);
        end
        OPC_OPIMM: if (funct3 == 3'b000) begin
          ok        = 1'b1;
          b.rs1     = inst[19:15];
          b.rd      = inst[11:7];
          b.imm     = XLEN'($signed(inst[31:20]));
          b.src_imm = 1'b1;
          b.we      = (inst[11:7] != 5'd0);
        end
        OPC_BRANCH: if (funct3[2:1] == 2'b00) begin
          ok        = 1'b1;
          b.rs1     = inst[19:15];
          b.rs2     = inst[24:20];
          b.imm     = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
          b.alu_sub = 1'b1;
          b.branch  = 1'b1;
          b.br_ne   = funct3[0];
        end
        OPC_LUI: begin
          ok        = 1'b1;
          b.rd      = inst[11:7];
          b.imm     = XLEN'($signed({inst[31:12], 12'b0}));
          b.src_imm = 1'b1;
          b.lui     = 1'b1;
          b.we      = (inst[11:7] != 5'd0);
        end
        default: ok = 1'b0;
      endcase
    end
`ifdef DECODE_ILLEGAL_EN
    b.illegal = !ok;
`else
    if (!ok) b = '0;
`endif
    return b;
  endfunction

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_inst;
  bundle_t         out_q;
  logic [XLEN-1:0] src_pc;
  logic [31:0]     src_inst;
  bundle_t         src_dec;
  logic            if_fire;
  logic            load_out;

  // skid entry is always older than the IF word, so it wins the source mux
  assign src_pc   = skid_valid ? skid_pc   : if_pc;
  assign src_inst = skid_valid ? skid_inst : if_inst;
  assign src_dec  = decode(src_inst);
  assign if_fire  = if_valid && if_ready;
  assign load_out = !id_valid || ex_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      id_pc      <= RESET_PC;
      out_q      <= '0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      id_valid   <= skid_valid || if_fire;
      skid_valid <= 1'b0;
      if (skid_valid || if_fire) begin
        id_pc <= src_pc;
        out_q <= src_dec;
      end
    end else if (if_fire) begin
      skid_valid <= 1'b1;
      skid_pc    <= if_pc;
      skid_inst  <= if_inst;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic illegal_seen;

  // if_fire implies an empty skid, so src_dec is the decode of the IF word here
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              illegal_seen <= 1'b0;
    else if (!flush && if_fire && src_dec.illegal) illegal_seen <= 1'b1;
  end

  assign if_ready   = !skid_valid && !illegal_seen;
  assign id_illegal = out_q.illegal;
`else
  assign if_ready   = !skid_valid;
  assign id_illegal = 1'b0;
`endif

  assign id_rs1     = out_q.rs1;
  assign id_rs2     = out_q.rs2;
  assign id_rd      = out_q.rd;
  assign id_imm     = out_q.imm;
  assign id_src_imm = out_q.src_imm;
  assign id_alu_sub = out_q.alu_sub;
  assign id_lui     = out_q.lui;
  assign id_branch  = out_q.branch;
  assign id_br_ne   = out_q.br_ne;
  assign id_we      = out_q.we;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles queued at IF handshake, compared at EX handshake.
module tb_decode_stage;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            if_valid = 1'b0, if_ready, flush = 1'b0, ex_ready = 1'b0, id_valid;
  logic [31:0]     if_pc = '0, if_inst = '0, id_pc, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_src_imm, id_alu_sub, id_lui, id_branch, id_br_ne, id_we, id_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_inst(if_inst), .flush(flush), .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_src_imm(id_src_imm),
    .id_alu_sub(id_alu_sub), .id_lui(id_lui), .id_branch(id_branch), .id_br_ne(id_br_ne),
    .id_we(id_we), .id_illegal(id_illegal)
  );

  // flags = {src_imm, alu_sub, lui, branch, br_ne, we, illegal}
  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [6:0]  flags;
  } ent_t;
  typedef struct {
    logic [31:0] pc;
    ent_t        e;
  } exp_t;

`ifdef DECODE_ILLEGAL_EN
  localparam logic [6:0] ILL = 7'b0000001;
`else
  localparam logic [6:0] ILL = 7'b0000000;
`endif

  ent_t        tab[12];
  exp_t        q[$];
  int          total = 0, bad = 0;
  logic        rnd = 1'b0;
  bit          accepted;
  int unsigned cur_idx = 0;
  logic [31:0] next_pc = 32'h0000_1000;
  logic [31:0] held_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t x;
    if (rnd) ex_ready = 1'($urandom_range(0, 1));
    #1;
    accepted = 0;
    if (flush) q.delete();
    else begin
      if (id_valid && ex_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got pc=%h want none", id_pc);
        end else begin
          x = q.pop_front();
          check("pc", id_pc, x.pc);
          check("rs1", 32'(id_rs1), 32'(x.e.rs1));
          check("rs2", 32'(id_rs2), 32'(x.e.rs2));
          check("rd", 32'(id_rd), 32'(x.e.rd));
          check("imm", id_imm, x.e.imm);
          check("flags", 32'({id_src_imm, id_alu_sub, id_lui, id_branch, id_br_ne, id_we, id_illegal}),
                32'(x.e.flags));
        end
      end
      if (if_valid && if_ready) begin
        q.push_back('{pc: if_pc, e: tab[cur_idx]});
        accepted = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int unsigned idx);
    cur_idx  = idx;
    if_valid = 1'b1;
    if_pc    = next_pc;
    if_inst  = tab[idx].inst;
    next_pc  = next_pc + 32'd4;
    for (int unsigned n = 0; n < 40; n++) begin
      tick();
      if (accepted) return;
    end
    total++; bad++;
    $display("FAIL send_timeout: got no handshake want accept idx=%0d", idx);
  endtask

  task automatic idle(input int unsigned n);
    if_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    tab[0]  = '{32'h00500093, 5'd0, 5'd0, 5'd1, 32'd5,        7'b1000010};
    tab[1]  = '{32'h402081B3, 5'd1, 5'd2, 5'd3, 32'd0,        7'b0100010};
    tab[2]  = '{32'hFE209CE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 7'b0101100};
    tab[3]  = '{32'h00208863, 5'd1, 5'd2, 5'd0, 32'd16,       7'b0101000};
    tab[4]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 32'h12345000, 7'b1010010};
    tab[5]  = '{32'h00100013, 5'd0, 5'd0, 5'd0, 32'd1,        7'b1000000};
    tab[6]  = '{32'h00208233, 5'd1, 5'd2, 5'd4, 32'd0,        7'b0000010};
    tab[7]  = '{32'hFFF30393, 5'd6, 5'd0, 5'd7, 32'hFFFFFFFF, 7'b1000010};
    tab[8]  = '{32'h00002003, 5'd0, 5'd0, 5'd0, 32'd0,        ILL};
    tab[9]  = '{32'h00500090, 5'd0, 5'd0, 5'd0, 32'd0,        ILL};
    tab[10] = '{32'h202081B3, 5'd0, 5'd0, 5'd0, 32'd0,        ILL};
    tab[11] = '{32'h0020C863, 5'd0, 5'd0, 5'd0, 32'd0,        ILL};

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_ready", 32'(if_ready), 32'd1);
    check("rst_pc", id_pc, RPC);
    check("rst_imm", id_imm, 32'd0);
    check("rst_fields", 32'({id_rs1, id_rs2, id_rd, id_src_imm, id_alu_sub, id_lui, id_branch,
                              id_br_ne, id_we, id_illegal}), 32'd0);
    reset = 1'b0;

    // single word, one-cycle latency
    ex_ready = 1'b1;
    send(0);
    if_valid = 1'b0;
    check("lat_valid", 32'(id_valid), 32'd1);
    check("lat_rd", 32'(id_rd), 32'd1);
    idle(2);

    // back-to-back stream with EX always ready
    for (int unsigned i = 1; i < 8; i++) send(i);
    idle(2);

    // random gaps and random backpressure
    rnd = 1'b1;
    for (int unsigned i = 0; i < 24; i++) begin
      send(i % 8);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    rnd = 1'b0;
    ex_ready = 1'b1;
    idle(4);
    check("drain_rand", 32'(q.size()), 32'd0);

    // stall: first held in output reg, second in skid
    ex_ready = 1'b0;
    held_pc  = next_pc;
    send(6);
    send(7);
    if_valid = 1'b0;
    check("stall_ready", 32'(if_ready), 32'd0);
    check("stall_valid", 32'(id_valid), 32'd1);
    idle(3);
    check("stall_hold_pc", id_pc, held_pc);
    check("stall_hold_ready", 32'(if_ready), 32'd0);
    ex_ready = 1'b1;
    idle(3);
    check("stall_ready_back", 32'(if_ready), 32'd1);
    check("drain_stall", 32'(q.size()), 32'd0);

    // flush with output reg, skid and an offered word all occupied
    ex_ready = 1'b0;
    send(0);
    send(1);
    cur_idx  = 2;
    if_valid = 1'b1;
    if_pc    = next_pc;
    if_inst  = tab[2].inst;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_ready", 32'(if_ready), 32'd1);
    ex_ready = 1'b1;
    idle(3);

    // flush drops a word even while if_ready is high
    cur_idx  = 4;
    if_valid = 1'b1;
    if_pc    = next_pc;
    if_inst  = tab[4].inst;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush2_valid", 32'(id_valid), 32'd0);
    idle(2);
    check("drain_flush", 32'(q.size()), 32'd0);

    // asynchronous reset with words in flight
    ex_ready = 1'b0;
    send(4);
    send(5);
    if_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(id_valid), 32'd0);
    check("arst_ready", 32'(if_ready), 32'd1);
    check("arst_pc", id_pc, RPC);
    check("arst_imm", id_imm, 32'd0);
    q.delete();
    @(negedge clk);
    reset    = 1'b0;
    ex_ready = 1'b1;
    idle(2);

    // unsupported encodings
`ifdef DECODE_ILLEGAL_EN
    send(8);
    idle(4);
    check("ill_halt_ready", 32'(if_ready), 32'd0);
`else
    for (int unsigned i = 8; i < 12; i++) send(i);
    idle(3);
    check("nop_ready", 32'(if_ready), 32'd1);
`endif
    check("drain_final", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
